// File: rtl/hls_seq_pkg.sv
// rtl/hls_seq_pkg.sv - shared state encoding and saturating arithmetic for the call sequencer
package hls_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_WAIT   = 2'd2,
      ST_DONE   = 2'd3
   } seq_state_t;

   localparam int SAT_MAX_W = 64;
   localparam int SAT_SUM_W = SAT_MAX_W + 1;

   // Unsigned add clamped to the largest value representable in w bits (w <= SAT_MAX_W).
   function automatic logic [SAT_MAX_W-1:0] sat_add(input logic [SAT_MAX_W-1:0] a,
                                                    input logic [SAT_MAX_W-1:0] b,
                                                    input int w);
      logic [SAT_SUM_W-1:0] sum;
      logic [SAT_SUM_W-1:0] lim;
      sum = {1'b0, a} + {1'b0, b};
      lim = (SAT_SUM_W'(1) << w) - SAT_SUM_W'(1);
      if (sum > lim)
         return lim[SAT_MAX_W-1:0];
      return sum[SAT_MAX_W-1:0];
   endfunction

endpackage

// File: rtl/hls_sat_counter.sv
// rtl/hls_sat_counter.sv - clearable counter with saturating increment and accumulate
module hls_sat_counter
   import hls_seq_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         inc,
   input  logic         add_en,
   input  logic [W-1:0] add_val,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (add_en)
         count <= W'(sat_add(SAT_MAX_W'(count), SAT_MAX_W'(add_val), W));
      else if (inc)
         count <= W'(sat_add(SAT_MAX_W'(count), SAT_MAX_W'(1), W));
   end

endmodule

// File: rtl/hls_call_sequencer.sv
// rtl/hls_call_sequencer.sv - issues lockstep start/finish calls to accelerator tops and times them
module hls_call_sequencer
   import hls_seq_pkg::*;
#(
   parameter int NUM_CH  = 1,
   parameter int CALL_W  = 16,
   parameter int CYC_W   = 32,
   parameter int TIMEOUT = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   input  logic [CALL_W-1:0] num_calls,
   output logic              busy,
   output logic              done,
   output logic [NUM_CH-1:0] acc_start,
   input  logic [NUM_CH-1:0] acc_ready,
   input  logic [NUM_CH-1:0] acc_finish,
   output logic [CALL_W-1:0] calls_done,
   output logic [CYC_W-1:0]  last_call_cycles,
   output logic [CYC_W-1:0]  max_call_cycles,
   output logic [CYC_W-1:0]  total_cycles,
   output logic              timeout_err,
   output logic [NUM_CH-1:0] timeout_ch
);

   seq_state_t        state;
   seq_state_t        state_nx;
   logic              start_q;
   logic [CALL_W-1:0] num_calls_q;
   logic [NUM_CH-1:0] seen;
   logic [NUM_CH-1:0] fin_eff;
   logic [CYC_W-1:0]  call_cyc;
   logic              run_take;
   logic              launch_fire;
   logic              call_complete;
   logic              timed_out;
   logic              last_call;

   assign acc_start = {NUM_CH{start_q}};

   // Finishes only count in WAIT after the start cycle itself.
   assign fin_eff       = (state == ST_WAIT && !start_q) ? acc_finish : '0;
   assign run_take      = (state == ST_IDLE) && run;
   assign launch_fire   = (state == ST_LAUNCH) && (&acc_ready);
   assign call_complete = (state == ST_WAIT) && !start_q && (&(seen | fin_eff));
   assign timed_out     = (TIMEOUT > 0) && (state == ST_WAIT) && !call_complete &&
                          (call_cyc >= CYC_W'(TIMEOUT));
   assign last_call     = ((calls_done + CALL_W'(1)) == num_calls_q);

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:   if (run) state_nx = (num_calls == '0) ? ST_DONE : ST_LAUNCH;
         ST_LAUNCH: if (&acc_ready) state_nx = ST_WAIT;
         ST_WAIT: begin
            if (call_complete)
               state_nx = last_call ? ST_DONE : ST_LAUNCH;
            else if (timed_out)
               state_nx = ST_DONE;
         end
         ST_DONE:   state_nx = ST_IDLE;
         default:   state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state            <= ST_IDLE;
         busy             <= 1'b0;
         done             <= 1'b0;
         start_q          <= 1'b0;
         num_calls_q      <= '0;
         seen             <= '0;
         calls_done       <= '0;
         last_call_cycles <= '0;
         max_call_cycles  <= '0;
         timeout_err      <= 1'b0;
         timeout_ch       <= '0;
      end else begin
         state   <= state_nx;
         busy    <= (state_nx != ST_IDLE);
         done    <= (state_nx == ST_DONE);
         start_q <= launch_fire;

         if (run_take) begin
            num_calls_q      <= num_calls;
            calls_done       <= '0;
            last_call_cycles <= '0;
            max_call_cycles  <= '0;
            timeout_err      <= 1'b0;
            timeout_ch       <= '0;
         end

         if (launch_fire)
            seen <= '0;
         else if (state == ST_WAIT)
            seen <= seen | fin_eff;

         // The call counter value in the completing cycle is exactly finish - start.
         if (call_complete) begin
            last_call_cycles <= call_cyc;
            if (call_cyc > max_call_cycles)
               max_call_cycles <= call_cyc;
            calls_done <= calls_done + CALL_W'(1);
         end

         if (timed_out) begin
            timeout_err <= 1'b1;
            timeout_ch  <= ~seen & ~fin_eff;
         end
      end
   end

   hls_sat_counter #(.W(CYC_W)) u_call_cnt (
      .clk     (clk),
      .reset   (reset),
      .clear   (launch_fire),
      .inc     (state == ST_WAIT),
      .add_en  (1'b0),
      .add_val ('0),
      .count   (call_cyc)
   );

   hls_sat_counter #(.W(CYC_W)) u_total_cnt (
      .clk     (clk),
      .reset   (reset),
      .clear   (run_take),
      .inc     (1'b0),
      .add_en  (call_complete),
      .add_val (call_cyc),
      .count   (total_cycles)
   );

endmodule

// File: doc/hls_call_sequencer.md
# hls_call_sequencer

Synthesizable call sequencer for SmartHLS-generated accelerator tops (e.g. sobel_filter_top) using the start/ready/finish handshake. It issues a programmable number of back-to-back calls to NUM_CH accelerator instances in lockstep, waits for every instance to finish each call, and records per-call and aggregate cycle latency plus a watchdog timeout. It sits between the system controller and one or more accelerator tops, replacing bench-only call loops with hardware usable on-chip and in co-simulation.

## Interface
Parameters:
- NUM_CH, 1: number of accelerator instances driven in lockstep (1..32)
- CALL_W, 16: width of the call-count fields
- CYC_W, 32: width of the cycle counters
- TIMEOUT, 0: per-call watchdog limit in cycles; 0 disables the watchdog

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- run  in  1  one-cycle request to start a sequence; sampled only in IDLE
- num_calls  in  CALL_W  number of calls for the sequence; latched with run
- busy  out  1  high from the cycle after run is accepted until DONE
- done  out  1  one-cycle pulse at end of sequence (normal or aborted)
- acc_start  out  NUM_CH  start to each accelerator; identical bits, one-cycle pulse
- acc_ready  in  NUM_CH  ready from each accelerator
- acc_finish  in  NUM_CH  finish pulse from each accelerator
- calls_done  out  CALL_W  completed calls in current/last sequence
- last_call_cycles  out  CYC_W  latency of most recent completed call
- max_call_cycles  out  CYC_W  largest call latency in the sequence
- total_cycles  out  CYC_W  sum of call latencies in the sequence
- timeout_err  out  1  sticky until next accepted run; set on watchdog abort
- timeout_ch  out  NUM_CH  channels that had not finished at abort

## Operation
- States: IDLE, LAUNCH, WAIT, DONE.
- IDLE: run=1 latches num_calls, clears calls_done, last/max/total, timeout_err, timeout_ch; num_calls≠0 → LAUNCH, num_calls=0 → DONE (no acc_start issued).
- LAUNCH: wait until acc_ready is all-ones; then assert acc_start (all bits) for exactly one cycle, clear seen mask and call counter → WAIT.
- WAIT: call counter increments each cycle (saturating at all-ones). acc_finish[c]=1 sets seen[c]. When (seen | acc_finish) is all-ones: last_call_cycles = latency, max_call_cycles = max(max, latency), total_cycles += latency (saturating), calls_done += 1; if calls_done reaches num_calls → DONE, else → LAUNCH.
- Latency: acc_start high in cycle S, final required finish high in cycle F → latency = F − S. Channels finishing in different cycles: F is the last one.
- Watchdog (TIMEOUT≠0): if latency reaches TIMEOUT without all channels finished → timeout_err=1, timeout_ch = ~seen & ~acc_finish, no stats update for that call, → DONE.
- DONE: done=1 for one cycle, → IDLE. Statistics hold until next accepted run.
- Ignored: run while busy; acc_finish in IDLE, LAUNCH, DONE, and in the acc_start cycle itself; repeat finish from an already-seen channel.

## Timing
- Reset values: busy=0, done=0, acc_start=0, calls_done=0, all cycle outputs 0, timeout_err=0, timeout_ch=0; state IDLE. Reset mid-sequence drops acc_start immediately (asynchronous), no done pulse.
- All outputs registered.
- run accepted at edge E → busy=1 after E; if acc_ready all-ones, acc_start high in cycle after LAUNCH entry (2 cycles after run).
- Finish-to-relaunch: all-finished sampled at edge → LAUNCH next cycle → acc_start next cycle if ready; minimum 2 idle cycles between consecutive acc_start pulses.
- done asserts the cycle after the final call completes; busy falls together with done.
- Counter saturation: call counter and total_cycles stick at 2^CYC_W−1; calls_done never exceeds num_calls.

## Structure
- Package hls_seq_pkg: state enum (IDLE, LAUNCH, WAIT, DONE), saturating-add function.
- Sub-module hls_sat_counter (width parameter, clear/increment/add, saturating) used for the call counter and total_cycles.
- Per-channel seen mask and max comparator stay in the top level.

## Test plan
- NUM_CH=1, num_calls=3, model finishes 10 cycles after each start → three acc_start pulses, calls_done=3, last=max=10, total=30, one done pulse.
- NUM_CH=4, channels finish at latencies 5,9,7,6 → single call recorded latency 9, no relaunch before channel 1 finishes.
- TIMEOUT=20, channel 2 never finishes → done at cycle 20 after start, timeout_err=1, timeout_ch=4'b0100, calls_done=0.
- num_calls=0 → done one cycle after run, no acc_start, stats zero; run during busy → ignored, calls_done unaffected.
- acc_ready low for 7 cycles in LAUNCH → acc_start delayed until ready, latency excludes the wait.
- reset low mid-WAIT → acc_start, busy, stats all 0 immediately; subsequent run=1, num_calls=1 completes normally.
